// File: rtl/run_event_logger.sv
// rtl/run_event_logger.sv - run length/polarity recorder with record FIFO and drop statistics
module run_event_logger #(
    parameter int DET_LEN = 4,
    parameter int LEN_W   = 8,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             y,
    input  logic             clr,
    input  logic             rec_ready,
    output logic             rec_valid,
    output logic             rec_pol,
    output logic [LEN_W-1:0] rec_len,
    output logic             ovf,
    output logic [7:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_nx;
    logic             a_d;
    logic             pol, pol_nx;
    logic [LEN_W-1:0] len, len_nx;
    logic             push;

    logic [LEN_W:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, pop, wr_en, drop;
    logic [LEN_W:0]   head;

    // Run tracker registers; a reset mid-run simply discards the partial run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a_d   <= 1'b0;
            pol   <= 1'b0;
            len   <= '0;
        end else begin
            state <= state_nx;
            a_d   <= a;
            pol   <= pol_nx;
            len   <= len_nx;
        end
    end

    // Next-state: latch polarity at run start, count while y holds, push when y drops.
    always_comb begin
        state_nx = state;
        pol_nx   = pol;
        len_nx   = len;
        push     = 1'b0;
        case (state)
            IDLE: begin
                if (y) begin
                    state_nx = RUN;
                    pol_nx   = a_d;
                    len_nx   = LEN_W'(DET_LEN);
                end
            end
            RUN: begin
                if (y) begin
                    if (len != {LEN_W{1'b1}}) begin
                        len_nx = len + LEN_W'(1);
                    end
                end else begin
                    push     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A push into a full FIFO is still accepted if the head leaves in the same cycle.
    always_comb begin
        full  = (count == (AW+1)'(DEPTH));
        pop   = rec_valid & rec_ready;
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;
    end

    // Record storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {pol, len};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Loss statistics; clear has priority over a drop in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf      <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (clr) begin
            ovf      <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Head record outputs, forced to zero while the FIFO is empty.
    always_comb begin
        head      = mem[rd_ptr];
        rec_valid = (count != '0);
        rec_pol   = rec_valid & head[LEN_W];
        rec_len   = rec_valid ? head[LEN_W-1:0] : '0;
    end

endmodule

// File: doc/run_event_logger.md
Name: run_event_logger

Overview:
- Sits directly downstream of the 4-bit run pattern detector. Consumes the detector's serial input bit `a` and its run flag `y`.
- Measures the full length and polarity of each qualifying run: DET_LEN or more consecutive equal bits.
- Queues one record per run in a small FIFO, read out over a valid/ready interface.
- Keeps overflow/drop statistics so firmware can detect lost events.

Parameters:
- DET_LEN, 4, run length at which the upstream detector asserts y; used as the length offset.
- LEN_W, 8, width of the recorded run length; the length saturates at 2^LEN_W-1.
- DEPTH, 4, FIFO depth in records; must be a power of 2 and at least 2.

Ports:
- clk  in  1  rising-edge clock shared with the detector.
- reset  in  1  asynchronous, active-low reset.
- a  in  1  serial bit stream, the same signal that feeds the detector.
- y  in  1  detector run flag (registered-state output of the detector).
- clr  in  1  synchronous clear of ovf and drop_cnt; FIFO contents are untouched.
- rec_ready  in  1  consumer ready.
- rec_valid  out  1  FIFO head record valid.
- rec_pol  out  1  run polarity: 1 = run of ones, 0 = run of zeros.
- rec_len  out  LEN_W  total run length in bits.
- ovf  out  1  sticky flag: at least one record was dropped.
- drop_cnt  out  8  number of dropped records, saturating at 255.

Behaviour:
- Reset is asynchronous and active-low. While reset=0:
  - FSM goes to IDLE.
  - a_d, len, pol, FIFO pointers and count are all 0.
  - rec_valid, rec_pol, rec_len, ovf and drop_cnt are 0.
  - Reset mid-run discards the partial run; no record is pushed.
- a_d is a 1-cycle register of `a`. While y=1, a_d holds the bit that completed the detector's run.
- FSM states: IDLE and RUN.
  - IDLE, y=1: go to RUN; pol<=a_d; len<=DET_LEN.
  - IDLE, y=0: stay in IDLE.
  - RUN, y=1: len<=len+1, saturating at 2^LEN_W-1 (no wrap).
  - RUN, y=0: push {pol,len} into the FIFO; go to IDLE.
- Resulting length: a run of N>=DET_LEN bits holds y high for N-DET_LEN+1 cycles, so the recorded len = N.
- Back-to-back runs are always separated by at least one y=0 cycle (the detector passes through its non-terminal states), so every run produces exactly one push.
- A push and a new run start cannot coincide.
- FIFO:
  - rec_valid = (count != 0).
  - rec_pol and rec_len are driven from the head entry, and are 0 when the FIFO is empty.
  - Pop occurs when rec_valid & rec_ready.
  - A pushed record is visible at rec_valid in the cycle after the push cycle (1-cycle latency when the FIFO is empty).
  - rec_pol and rec_len must remain stable while rec_valid=1 and rec_ready=0.
- Push when full:
  - Without a simultaneous pop: the record is dropped, ovf<=1, and drop_cnt increments (saturating at 255).
  - With a simultaneous pop: the push is accepted and count stays at DEPTH.
- Simultaneous push and pop when not full or empty: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- clr=1 clears ovf and drop_cnt to 0 on the next edge. If a drop occurs in the same cycle as clr, clr wins: ovf=0 and drop_cnt=0.
- y=1 arriving in the cycle straight after reset release is legal: treat it as a run start.

Test Plan:
- Four ones then a zero (a=1,1,1,1,0 driven through the detector), rec_ready=1 -> one record with pol=1, len=4; rec_valid high for exactly 1 cycle.
- Run of 9 zeros followed by 5 ones, rec_ready=1 -> two records in order: {pol=0, len=9}, then {pol=1, len=5}.
- Run of 300 ones with LEN_W=8 -> len saturates at 255; recorded {pol=1, len=255}.
- rec_ready=0 while 6 qualifying runs of length 4 occur (DEPTH=4) -> 4 records retained in order; ovf=1; drop_cnt=2. Then raise rec_ready -> 4 records drain with stable outputs, then rec_valid=0.
- FIFO full with rec_ready=1 in the same cycle as a push -> no drop; ovf stays 0; count stays 4. Then pulse clr after a forced drop -> ovf=0 and drop_cnt=0 on the next cycle.
- Assert reset=0 asynchronously mid-run (len=6) with 2 records queued -> rec_valid=0 immediately. After release, no stale record appears; the next 4-run yields len=4.
